// File: rtl/jtdd_mcu_bridge.sv
// MCU-side end of the main-CPU/MCU link.
// Owns the shared communication RAM (true dual-port, 2^AW x 8) and turns the
// main CPU's NMI and halt requests into MCU pins. It also returns the
// bus-available flag and the MCU-to-main interrupt.
//   main_*      : main CPU RAM port (main_cs = com_cs, written on main_cen)
//   mcu_*       : HD63701 RAM port (written on mcu_cen, blocked while halted)
//   nmi_set     -> mcu_nmi     (cleared by mcu_nmi_ack on mcu_cen)
//   halt_req    -> mcu_haltn, mcu_ban (mcu_ban after BAN_DLY mcu_cen ticks)
//   mcu_irq_port rising edge -> mcu_irqmain
module jtdd_mcu_bridge #(
  parameter int AW      = 9,
  parameter int BAN_DLY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          main_cen,
  input  logic          mcu_cen,
  input  logic          main_cs,
  input  logic          main_rnw,
  input  logic [AW-1:0] main_addr,
  input  logic [7:0]    main_dout,
  output logic [7:0]    main_din,
  input  logic          nmi_set,
  input  logic          halt_req,
  output logic          mcu_ban,
  output logic          mcu_irqmain,
  input  logic          mcu_cs,
  input  logic          mcu_wr,
  input  logic [AW-1:0] mcu_addr,
  input  logic [7:0]    mcu_dout,
  output logic [7:0]    mcu_din,
  output logic          mcu_nmi,
  input  logic          mcu_nmi_ack,
  input  logic          mcu_irq_port,
  output logic          mcu_haltn
);

  localparam int CW = (BAN_DLY < 1) ? 1 : $clog2(BAN_DLY + 1);

  typedef enum logic [1:0] {RUN, STOP, HALTED} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          main_we;
  logic          mcu_we;
  logic          nmi_last;
  logic          nmi_rise;
  logic          irq_last;
  logic          irq_rise;
  logic          irq_done;

  logic [7:0] mem [0:(1<<AW)-1];

  assign main_we  = main_cs & ~main_rnw & main_cen;
  assign mcu_we   = mcu_cs & mcu_wr & mcu_cen & (state != HALTED);
  assign nmi_rise = nmi_set & ~nmi_last;
  assign irq_rise = mcu_cen & mcu_irq_port & ~irq_last;
  assign cnt_nxt  = cnt + CW'(mcu_cen);

  // Contents are never reset. On a same-address collision the main CPU wins.
  always_ff @(posedge clk) begin
    if (main_we) mem[main_addr] <= main_dout;
    if (mcu_we && !(main_we && (main_addr == mcu_addr))) mem[mcu_addr] <= mcu_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_din <= '0;
      mcu_din  <= '0;
    end else begin
      main_din <= mem[main_addr];
      mcu_din  <= mem[mcu_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_last <= 1'b0;
      mcu_nmi  <= 1'b0;
    end else begin
      nmi_last <= nmi_set;
      if (nmi_rise)                   mcu_nmi <= 1'b1;
      else if (mcu_nmi_ack & mcu_cen) mcu_nmi <= 1'b0;
    end
  end

  // irq_done records a main_cen seen while mcu_irqmain was already high, so
  // the flag drops one clk later. A fresh edge re-arms by clearing irq_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_last    <= 1'b0;
      irq_done    <= 1'b0;
      mcu_irqmain <= 1'b0;
    end else begin
      if (mcu_cen) irq_last <= mcu_irq_port;
      if (irq_rise) begin
        mcu_irqmain <= 1'b1;
        irq_done    <= 1'b0;
      end else if (irq_done) begin
        mcu_irqmain <= 1'b0;
        irq_done    <= 1'b0;
      end else if (mcu_irqmain & main_cen) begin
        irq_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      mcu_ban   <= 1'b0;
      mcu_haltn <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          mcu_haltn <= 1'b1;
          mcu_ban   <= 1'b0;
          if (halt_req) begin
            state     <= STOP;
            mcu_haltn <= 1'b0;
            cnt       <= '0;
          end
        end
        STOP: begin
          if (!halt_req) begin
            state     <= RUN;
            mcu_haltn <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt_nxt;
            // Look at the incremented value so mcu_ban rises on the tick
            // that completes the delay rather than one clk later.
            if (cnt_nxt >= CW'(BAN_DLY)) begin
              state   <= HALTED;
              mcu_ban <= 1'b1;
            end
          end
        end
        HALTED: begin
          if (!halt_req) begin
            state     <= RUN;
            mcu_ban   <= 1'b0;
            mcu_haltn <= 1'b1;
            cnt       <= '0;
          end
        end
        default: begin
          state     <= RUN;
          mcu_ban   <= 1'b0;
          mcu_haltn <= 1'b1;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtdd_mcu_bridge.sv
module tb_jtdd_mcu_bridge;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          main_cen, mcu_cen;
  logic          main_cs, main_rnw;
  logic [AW-1:0] main_addr;
  logic [7:0]    main_dout, main_din;
  logic          nmi_set, halt_req;
  logic          mcu_ban, mcu_irqmain;
  logic          mcu_cs, mcu_wr;
  logic [AW-1:0] mcu_addr;
  logic [7:0]    mcu_dout, mcu_din;
  logic          mcu_nmi, mcu_nmi_ack, mcu_irq_port, mcu_haltn;

  int total = 0;
  int bad   = 0;

  jtdd_mcu_bridge #(.AW(AW), .BAN_DLY(2)) dut (
    .clk(clk), .rst(rst), .main_cen(main_cen), .mcu_cen(mcu_cen),
    .main_cs(main_cs), .main_rnw(main_rnw), .main_addr(main_addr),
    .main_dout(main_dout), .main_din(main_din), .nmi_set(nmi_set),
    .halt_req(halt_req), .mcu_ban(mcu_ban), .mcu_irqmain(mcu_irqmain),
    .mcu_cs(mcu_cs), .mcu_wr(mcu_wr), .mcu_addr(mcu_addr),
    .mcu_dout(mcu_dout), .mcu_din(mcu_din), .mcu_nmi(mcu_nmi),
    .mcu_nmi_ack(mcu_nmi_ack), .mcu_irq_port(mcu_irq_port),
    .mcu_haltn(mcu_haltn)
  );

  always #5 clk = ~clk;

  // One rising edge; returns at the following falling edge where outputs are
  // sampled and new inputs driven.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    main_cen = 0; mcu_cen = 0; main_cs = 0; main_rnw = 1; main_addr = '0;
    main_dout = '0; nmi_set = 0; halt_req = 0; mcu_cs = 0; mcu_wr = 0;
    mcu_addr = '0; mcu_dout = '0; mcu_nmi_ack = 0; mcu_irq_port = 0;
    @(negedge clk); @(negedge clk);
    total++; if (main_din !== 8'h00) begin bad++; $display("FAIL rst_main_din got=%h exp=00", main_din); end
    total++; if (mcu_din !== 8'h00) begin bad++; $display("FAIL rst_mcu_din got=%h exp=00", mcu_din); end
    total++; if ({mcu_ban, mcu_irqmain, mcu_nmi, mcu_haltn} !== 4'b0001) begin
      bad++; $display("FAIL rst_flags got ban/irq/nmi/haltn=%b exp=0001", {mcu_ban, mcu_irqmain, mcu_nmi, mcu_haltn});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_main_to_mcu();
    main_cs = 1; main_rnw = 0; main_addr = 9'h123; main_dout = 8'h5A; main_cen = 1;
    step();
    main_cs = 0; main_rnw = 1; main_cen = 0; mcu_addr = 9'h123;
    step();
    total++; if (mcu_din !== 8'h5A) begin bad++; $display("FAIL m2m_mcu_din got=%h exp=5a", mcu_din); end
    total++; if (main_din !== 8'h5A) begin bad++; $display("FAIL m2m_main_din got=%h exp=5a", main_din); end
    // read during write returns the old contents
    main_cs = 1; main_rnw = 0; main_dout = 8'h6B; main_cen = 1;
    step();
    total++; if (mcu_din !== 8'h5A) begin bad++; $display("FAIL rdw_old got=%h exp=5a", mcu_din); end
    main_cs = 0; main_rnw = 1; main_cen = 0;
    step();
    total++; if (mcu_din !== 8'h6B) begin bad++; $display("FAIL rdw_new got=%h exp=6b", mcu_din); end
  endtask

  task automatic test_mcu_to_main();
    mcu_cs = 1; mcu_wr = 1; mcu_cen = 1; mcu_addr = 9'h010; mcu_dout = 8'hA5; main_addr = 9'h010;
    step();
    mcu_cs = 0; mcu_wr = 0; mcu_cen = 0;
    step();
    total++; if (main_din !== 8'hA5) begin bad++; $display("FAIL mcu2main got=%h exp=a5", main_din); end
    // no write without mcu_cen
    mcu_cs = 1; mcu_wr = 1; mcu_dout = 8'hFF;
    step();
    mcu_cs = 0; mcu_wr = 0;
    step();
    total++; if (main_din !== 8'hA5) begin bad++; $display("FAIL mcu_nocen got=%h exp=a5", main_din); end
  endtask

  task automatic test_collision();
    main_cs = 1; main_rnw = 0; main_addr = 9'h040; main_dout = 8'h11; main_cen = 1;
    mcu_cs = 1; mcu_wr = 1; mcu_addr = 9'h040; mcu_dout = 8'h22; mcu_cen = 1;
    step();
    main_cs = 0; main_rnw = 1; main_cen = 0; mcu_cs = 0; mcu_wr = 0; mcu_cen = 0;
    step();
    total++; if (main_din !== 8'h11) begin bad++; $display("FAIL coll_main got=%h exp=11", main_din); end
    total++; if (mcu_din !== 8'h11) begin bad++; $display("FAIL coll_mcu got=%h exp=11", mcu_din); end
  endtask

  task automatic test_nmi();
    nmi_set = 1;
    step();
    total++; if (mcu_nmi !== 1'b1) begin bad++; $display("FAIL nmi_set got=%b exp=1", mcu_nmi); end
    nmi_set = 0; mcu_nmi_ack = 1; mcu_cen = 0;
    step();
    total++; if (mcu_nmi !== 1'b1) begin bad++; $display("FAIL nmi_ack_nocen got=%b exp=1", mcu_nmi); end
    mcu_cen = 1;
    step();
    total++; if (mcu_nmi !== 1'b0) begin bad++; $display("FAIL nmi_ack got=%b exp=0", mcu_nmi); end
    mcu_nmi_ack = 0; mcu_cen = 0; nmi_set = 1;
    step();
    nmi_set = 0;
    step();
    nmi_set = 1; mcu_nmi_ack = 1; mcu_cen = 1;
    step();
    total++; if (mcu_nmi !== 1'b1) begin bad++; $display("FAIL nmi_set_wins got=%b exp=1", mcu_nmi); end
    // level held high is not a new edge, so the ack now clears
    step();
    total++; if (mcu_nmi !== 1'b0) begin bad++; $display("FAIL nmi_level got=%b exp=0", mcu_nmi); end
    nmi_set = 0; mcu_nmi_ack = 0; mcu_cen = 0;
    step();
  endtask

  task automatic test_irq();
    mcu_irq_port = 0; mcu_cen = 1; main_cen = 0;
    step();
    mcu_irq_port = 1; mcu_cen = 0;
    step();
    total++; if (mcu_irqmain !== 1'b0) begin bad++; $display("FAIL irq_nocen got=%b exp=0", mcu_irqmain); end
    mcu_cen = 1;
    step();
    total++; if (mcu_irqmain !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", mcu_irqmain); end
    mcu_cen = 0;
    step();
    step();
    total++; if (mcu_irqmain !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b exp=1", mcu_irqmain); end
    main_cen = 1;
    step();
    total++; if (mcu_irqmain !== 1'b1) begin bad++; $display("FAIL irq_at_cen got=%b exp=1", mcu_irqmain); end
    main_cen = 0;
    step();
    total++; if (mcu_irqmain !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b exp=0", mcu_irqmain); end
    // re-arm: new edge right after a main_cen keeps it high for another one
    mcu_irq_port = 0; mcu_cen = 1;
    step();
    mcu_irq_port = 1;
    step();
    mcu_cen = 0; mcu_irq_port = 0;
    step();
    mcu_cen = 1;
    step();
    mcu_cen = 0; main_cen = 1;
    step();
    mcu_irq_port = 1; mcu_cen = 1; main_cen = 0;
    step();
    total++; if (mcu_irqmain !== 1'b1) begin bad++; $display("FAIL irq_rearm got=%b exp=1", mcu_irqmain); end
    mcu_cen = 0;
    step();
    total++; if (mcu_irqmain !== 1'b1) begin bad++; $display("FAIL irq_rearm_hold got=%b exp=1", mcu_irqmain); end
    main_cen = 1;
    step();
    main_cen = 0;
    step();
    total++; if (mcu_irqmain !== 1'b0) begin bad++; $display("FAIL irq_rearm_clear got=%b exp=0", mcu_irqmain); end
    mcu_irq_port = 0;
  endtask

  task automatic test_halt();
    main_cs = 1; main_rnw = 0; main_addr = 9'h005; main_dout = 8'h33; main_cen = 1;
    step();
    main_cs = 0; main_rnw = 1; main_cen = 0;
    halt_req = 1; mcu_cen = 0;
    step();
    total++; if ({mcu_haltn, mcu_ban} !== 2'b00) begin bad++; $display("FAIL halt_stop haltn/ban=%b exp=00", {mcu_haltn, mcu_ban}); end
    mcu_cen = 1;
    step();
    mcu_cen = 0;
    step();
    total++; if (mcu_ban !== 1'b0) begin bad++; $display("FAIL halt_early ban=%b exp=0", mcu_ban); end
    mcu_cen = 1;
    step();
    total++; if ({mcu_haltn, mcu_ban} !== 2'b01) begin bad++; $display("FAIL halt_ban haltn/ban=%b exp=01", {mcu_haltn, mcu_ban}); end
    mcu_cs = 1; mcu_wr = 1; mcu_addr = 9'h005; mcu_dout = 8'h77;
    step();
    mcu_cs = 0; mcu_wr = 0; mcu_cen = 0;
    step();
    total++; if (mcu_din !== 8'h33) begin bad++; $display("FAIL halt_blk_mcu got=%h exp=33", mcu_din); end
    total++; if (main_din !== 8'h33) begin bad++; $display("FAIL halt_blk_main got=%h exp=33", main_din); end
    halt_req = 0;
    step();
    total++; if ({mcu_haltn, mcu_ban} !== 2'b10) begin bad++; $display("FAIL halt_release haltn/ban=%b exp=10", {mcu_haltn, mcu_ban}); end
  endtask

  task automatic test_halt_abort();
    halt_req = 1; mcu_cen = 0;
    step();
    mcu_cen = 1;
    step();
    halt_req = 0; mcu_cen = 0;
    step();
    total++; if ({mcu_haltn, mcu_ban} !== 2'b10) begin bad++; $display("FAIL abort_run haltn/ban=%b exp=10", {mcu_haltn, mcu_ban}); end
    mcu_cen = 1;
    step();
    step();
    total++; if (mcu_ban !== 1'b0) begin bad++; $display("FAIL abort_noban ban=%b exp=0", mcu_ban); end
    // counter must restart from zero on the next halt
    halt_req = 1;
    step();
    step();
    total++; if (mcu_ban !== 1'b0) begin bad++; $display("FAIL abort_cnt_clr ban=%b exp=0", mcu_ban); end
    step();
    total++; if (mcu_ban !== 1'b1) begin bad++; $display("FAIL abort_reban ban=%b exp=1", mcu_ban); end
    mcu_cen = 0;
  endtask

  task automatic test_reset_mid();
    nmi_set = 1;
    step();
    total++; if ({mcu_nmi, mcu_ban} !== 2'b11) begin bad++; $display("FAIL mid_pre nmi/ban=%b exp=11", {mcu_nmi, mcu_ban}); end
    #2 rst = 1'b1;
    #1;
    total++; if ({mcu_ban, mcu_irqmain, mcu_nmi, mcu_haltn} !== 4'b0001) begin
      bad++; $display("FAIL mid_rst_flags got=%b exp=0001", {mcu_ban, mcu_irqmain, mcu_nmi, mcu_haltn});
    end
    total++; if ({main_din, mcu_din} !== 16'h0000) begin bad++; $display("FAIL mid_rst_din got=%h exp=0000", {main_din, mcu_din}); end
    nmi_set = 0; halt_req = 0;
    @(negedge clk);
    rst = 1'b0;
    step();
    total++; if ({mcu_nmi, mcu_haltn, mcu_ban} !== 3'b010) begin bad++; $display("FAIL mid_after nmi/haltn/ban=%b exp=010", {mcu_nmi, mcu_haltn, mcu_ban}); end
  endtask

  initial begin
    test_reset();
    test_main_to_mcu();
    test_mcu_to_main();
    test_collision();
    test_nmi();
    test_irq();
    test_halt();
    test_halt_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
